// File: rtl/regfile_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sequencer_pkg
//   Shared definitions for the register-file sequencer: default datapath and
//   address widths, instruction field positions, ALU opcode values and the
//   sequencer FSM state encoding.
//
//   Instruction word layout (16 bits):
//     [15:13] reserved, must be 000
//     [12:9]  opcode
//     [8:6]   DR  destination register
//     [5:3]   SA  source A register
//     [2:0]   SB  source B register (or immediate for LDI)
// -----------------------------------------------------------------------------
package regfile_sequencer_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_AW      = 3;
    localparam int INS_W       = 16;

    localparam int RSV_MSB     = 15;
    localparam int RSV_LSB     = 13;
    localparam int OP_LSB      = 9;
    localparam int OP_W        = 4;
    localparam int DR_LSB      = 6;
    localparam int SA_LSB      = 3;
    localparam int SB_LSB      = 0;
    localparam int REG_FIELD_W = 3;

    localparam logic [OP_W-1:0] OP_MOVA = 4'd0;
    localparam logic [OP_W-1:0] OP_INC  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd7;
    localparam logic [OP_W-1:0] OP_LDI  = 4'd8;
    localparam logic [OP_W-1:0] OP_MOVB = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } seq_state_t;

    // Opcodes above MOVB are unassigned.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_MOVB);
    endfunction

endpackage

// File: rtl/regfile_sequencer_seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Combinational ALU for the register-file sequencer.
//   Ports:
//     op     : opcode (see regfile_sequencer_pkg)
//     a, b   : register operands
//     imm    : immediate field, zero-extended for LDI
//     result : ALU result
//     c, v   : carry out of the top bit / signed overflow (arithmetic only;
//              logic and move ops report 0)
// -----------------------------------------------------------------------------
module seq_alu
    import regfile_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = REG_FIELD_W
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic             cin;
    logic [WIDTH:0]   sum;

    // One shared adder: INC is A+0+1, SUB is A+~B+1.
    always_comb begin
        a_op = a;
        b_op = '0;
        cin  = 1'b0;
        case (op)
            OP_INC: cin = 1'b1;
            OP_ADD: b_op = b;
            OP_SUB: begin
                b_op = ~b;
                cin  = 1'b1;
            end
            default: ;
        endcase
        sum = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_MOVA: result = a;
            OP_INC, OP_ADD, OP_SUB: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                // Same-sign operands giving an opposite-sign result.
                v      = (a_op[WIDTH-1] == b_op[WIDTH-1]) &&
                         (sum[WIDTH-1] != a_op[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_LDI:  result = {{(WIDTH-IMM_W){1'b0}}, imm};
            OP_MOVB: result = b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
//   Initiator side of the register-file port. Accepts one register-register
//   instruction at a time and sequences IDLE -> DECODE -> READ -> EXEC -> WB.
//   Ports:
//     CLK, RESET          : clock, asynchronous active-high reset
//     INS, INS_VALID      : instruction word and its valid
//     INS_READY           : sequencer can accept an instruction
//     AA, BA              : register-file read addresses
//     AD, BD              : register-file read data (one-cycle latency)
//     DA, DD, RW          : register-file write address / data / enable
//     DONE, ILLEGAL       : retire pulse / reject pulse
//     Z, N, C, V          : flags from the last executed ALU op
//
//   Handshake: an instruction transfers on a rising edge where INS_VALID and
//   INS_READY are both high. INS_READY is high only in IDLE; the source must
//   hold INS stable while INS_VALID is high and not yet accepted.
// -----------------------------------------------------------------------------
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [INS_W-1:0] INS,
    input  logic             INS_VALID,
    output logic             INS_READY,
    output logic [AW-1:0]    AA,
    output logic [AW-1:0]    BA,
    output logic [AW-1:0]    DA,
    output logic [WIDTH-1:0] DD,
    output logic             RW,
    input  logic [WIDTH-1:0] AD,
    input  logic [WIDTH-1:0] BD,
    output logic             DONE,
    output logic             ILLEGAL,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [INS_W-1:0] ins_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q, n_q, c_q, v_q;

    logic [OP_W-1:0]        op;
    logic [AW-1:0]          dr, sa, sb;
    logic [REG_FIELD_W-1:0] imm;
    logic                   ins_illegal;
    logic [WIDTH-1:0]       alu_result;
    logic                   alu_c, alu_v;

    assign op  = ins_q[OP_LSB +: OP_W];
    assign dr  = AW'(ins_q[DR_LSB +: REG_FIELD_W]);
    assign sa  = AW'(ins_q[SA_LSB +: REG_FIELD_W]);
    assign sb  = AW'(ins_q[SB_LSB +: REG_FIELD_W]);
    assign imm = ins_q[SB_LSB +: REG_FIELD_W];

    assign ins_illegal = (ins_q[RSV_MSB:RSV_LSB] != '0) || !op_legal(op);

    seq_alu #(
        .WIDTH (WIDTH),
        .IMM_W (REG_FIELD_W)
    ) u_alu (
        .op     (op),
        .a      (AD),
        .b      (BD),
        .imm    (imm),
        .result (alu_result),
        .c      (alu_c),
        .v      (alu_v)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            ins_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && INS_VALID) begin
                ins_q <= INS;
            end
            // AD/BD are valid here because AA/BA were held through READ.
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                z_q      <= (alu_result == '0);
                n_q      <= alu_result[WIDTH-1];
                c_q      <= alu_c;
                v_q      <= alu_v;
            end
        end
    end

    // All port outputs are decoded from the registered state, so DA/DD are
    // stable for the whole WB cycle and RW cannot glitch high elsewhere.
    always_comb begin
        state_d   = state_q;
        INS_READY = 1'b0;
        AA        = '0;
        BA        = '0;
        DA        = '0;
        DD        = '0;
        RW        = 1'b0;
        DONE      = 1'b0;
        ILLEGAL   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                INS_READY = 1'b1;
                if (INS_VALID) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                AA = sa;
                BA = sb;
                if (ins_illegal) begin
                    ILLEGAL = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                AA      = sa;
                BA      = sb;
                state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                RW      = 1'b1;
                DA      = dr;
                DD      = result_q;
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Z = z_q;
    assign N = n_q;
    assign C = c_q;
    assign V = v_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_sequencer
//   Directed bench for regfile_sequencer with a behavioural 8x16 register file
//   (registered reads, write on RW) and an expected write-back queue.
// -----------------------------------------------------------------------------
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    localparam int W  = 16;
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic [15:0]   INS       = '0;
    logic          INS_VALID = 1'b0;
    logic          INS_READY;
    logic [AW-1:0] AA, BA, DA;
    logic [W-1:0]  DD, AD, BD;
    logic          RW, DONE, ILLEGAL, Z, N, C, V;

    regfile_sequencer #(.WIDTH(W), .AW(AW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .INS       (INS),
        .INS_VALID (INS_VALID),
        .INS_READY (INS_READY),
        .AA        (AA),
        .BA        (BA),
        .DA        (DA),
        .DD        (DD),
        .RW        (RW),
        .AD        (AD),
        .BD        (BD),
        .DONE      (DONE),
        .ILLEGAL   (ILLEGAL),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V)
    );

    // ---------------- register file model ----------------
    logic [W-1:0]  rf [8];
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [W-1:0]  pl_data = '0;

    always @(posedge CLK) begin
        AD <= rf[AA];
        BD <= rf[BA];
        if (RW) rf[DA] <= DD;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int wb_count = 0;
    logic [AW+W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            wb_count = 0;
        end else if (RW === 1'b1) begin
            wb_count++;
            if (exp_q.size() == 0) check("unexpected_wb", 32'({DA, DD}), 32'hFFFF_FFFF);
            else check("wb_data", 32'({DA, DD}), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] dr,
                                       input logic [2:0] sa, input logic [2:0] sb);
        return {3'b000, op, dr, sa, sb};
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    // Returns one cycle after the acceptance edge (FSM in DECODE).
    task automatic issue(input logic [15:0] ins);
        int waited = 0;
        while (INS_READY !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (INS_READY !== 1'b1) check("ready_timeout", 32'(INS_READY), 32'd1);
        INS       = ins;
        INS_VALID = 1'b1;
        tick();
        INS_VALID = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] ins, input logic [AW-1:0] exp_da,
                          input logic [W-1:0] exp_dd, input logic [3:0] exp_zncv);
        exp_q.push_back({exp_da, exp_dd});
        issue(ins);
        for (int c = 1; c <= 3; c++) begin
            check("rw_early", 32'(RW), 32'd0);
            tick();
        end
        check("rw_wb", 32'(RW), 32'd1);
        check("done_wb", 32'(DONE), 32'd1);
        check("da_wb", 32'(DA), 32'(exp_da));
        check("dd_wb", 32'(DD), 32'(exp_dd));
        check("flags", 32'({Z, N, C, V}), 32'(exp_zncv));
        tick();
        check("rw_after", 32'(RW), 32'd0);
        check("ready_after", 32'(INS_READY), 32'd1);
    endtask

    task automatic run_illegal(input logic [15:0] ins, input logic [3:0] exp_zncv);
        issue(ins);
        check("illegal_pulse", 32'(ILLEGAL), 32'd1);
        check("illegal_rw", 32'(RW), 32'd0);
        check("illegal_done", 32'(DONE), 32'd0);
        tick();
        check("illegal_clear", 32'(ILLEGAL), 32'd0);
        check("illegal_idle", 32'(INS_READY), 32'd1);
        check("illegal_flags", 32'({Z, N, C, V}), 32'(exp_zncv));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ins_b;
        int first_rw, second_rw, n_rw, n_done;

        tick();
        tick();
        check("rst_ready", 32'(INS_READY), 32'd1);
        check("rst_bus", 32'({AA, BA, DA, DD, RW}), 32'd0);
        check("rst_pulses", 32'({DONE, ILLEGAL}), 32'd0);
        check("rst_flags", 32'({Z, N, C, V}), 32'd0);
        RESET = 1'b0;
        tick();

        // Reset during READ aborts with no write.
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        issue(mk(OP_ADD, 3'd3, 3'd1, 3'd2));
        tick();
        RESET = 1'b1;
        #1;
        check("midrst_rw", 32'(RW), 32'd0);
        check("midrst_ready", 32'(INS_READY), 32'd1);
        check("midrst_outs", 32'({AA, BA, DA, DD, DONE, ILLEGAL, Z, N, C, V}), 32'd0);
        tick();
        tick();
        RESET = 1'b0;
        tick();
        tick();
        check("midrst_wb_count", 32'(wb_count), 32'd0);

        // ADD 3+4
        run_op(mk(OP_ADD, 3'd3, 3'd1, 3'd2), 3'd3, 16'h0007, 4'b0000);

        // INC wrap, then MOVA of the wrapped register
        load(3'd5, 16'hFFFF);
        run_op(mk(OP_INC, 3'd5, 3'd5, 3'd0), 3'd5, 16'h0000, 4'b1010);
        run_op(mk(OP_MOVA, 3'd6, 3'd5, 3'd0), 3'd6, 16'h0000, 4'b1000);

        // SUB with borrow: 2-5
        load(3'd1, 16'h0002);
        load(3'd2, 16'h0005);
        run_op(mk(OP_SUB, 3'd0, 3'd1, 3'd2), 3'd0, 16'hFFFD, 4'b0100);

        // Signed overflow: 7FFF+1
        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0001);
        run_op(mk(OP_ADD, 3'd4, 3'd1, 3'd2), 3'd4, 16'h8000, 4'b0101);

        // DR == SA uses the old value: R1 = 7FFF ^ 0001
        run_op(mk(OP_XOR, 3'd1, 3'd1, 3'd2), 3'd1, 16'h7FFE, 4'b0000);

        // Illegal words leave the flags alone
        run_illegal(16'h2000, 4'b0000);
        run_illegal(mk(4'd12, 3'd0, 3'd0, 3'd0), 4'b0000);

        // Back-to-back with INS_VALID held high
        exp_q.push_back({3'd1, 16'h0007});
        exp_q.push_back({3'd2, 16'h000E});
        ins_b = mk(OP_ADD, 3'd2, 3'd1, 3'd1);
        issue(mk(OP_LDI, 3'd1, 3'd0, 3'd7));
        INS       = ins_b;
        INS_VALID = 1'b1;
        first_rw  = -1;
        second_rw = -1;
        n_rw      = 0;
        n_done    = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 6) INS_VALID = 1'b0;
            if (RW === 1'b1) begin
                n_rw++;
                if (first_rw < 0) first_rw = c;
                else second_rw = c;
            end
            if (DONE === 1'b1) n_done++;
            if (c == 4) check("b2b_ldi_dd", 32'(DD), 32'h0007);
            if (c == 9) begin
                check("b2b_add_dd", 32'(DD), 32'h000E);
                check("b2b_add_flags", 32'({Z, N, C, V}), 32'd0);
            end
            tick();
        end
        check("b2b_first_rw", 32'(first_rw), 32'd4);
        check("b2b_second_rw", 32'(second_rw), 32'd9);
        check("b2b_rw_count", 32'(n_rw), 32'd2);
        check("b2b_done_count", 32'(n_done), 32'd2);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
